// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, EX/MEM stage state, default width.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } stage_state_e;

  // Only signed add/sub can raise an arithmetic-overflow exception.
  function automatic logic op_can_trap(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_ex_mem_reg_if.sv
// EX -> EX/MEM -> MEM handshake and exception bundle for alu_ex_mem_reg.
interface alu_ex_mem_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic             alu_oflo;
  logic [2:0]       operation;
  logic             trap_oflo;
  logic [31:0]      pc;
  logic [4:0]       rd;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] store_data;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [4:0]       out_rd;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic [WIDTH-1:0] out_store_data;

  logic             exc_req;
  logic [31:0]      exc_epc;
  logic             exc_ack;

  // The stage itself.
  modport slave (
    input  in_valid, alu_result, alu_oflo, operation, trap_oflo, pc, rd,
           reg_write, mem_read, mem_write, store_data, flush, out_ready, exc_ack,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, exc_req, exc_epc
  );

  // The surrounding pipeline (EX, MEM and the exception handler).
  modport master (
    output in_valid, alu_result, alu_oflo, operation, trap_oflo, pc, rd,
           reg_write, mem_read, mem_write, store_data, flush, out_ready, exc_ack,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, exc_req, exc_epc
  );

endinterface

// File: rtl/alu_zero_detect.sv
// Zero flag for the ALU result: WIDTH-bit NOR reduction.
module alu_zero_detect #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o
);

  assign zero_o = ~|data_i;

endmodule

// File: rtl/alu_ex_mem_reg.sv
// EX/MEM pipeline register with zero flag and precise overflow trap for signed add/sub.
module alu_ex_mem_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  alu_ex_mem_reg_if.slave bus
);

  stage_state_e     state_q, state_d;
  logic             in_ready;
  logic             exc_req;
  logic             accept;
  logic             trap;
  logic             load;
  logic             drain;
  logic             zero;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      exc_epc_q, exc_epc_d;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic [4:0]       out_rd_q;
  logic             out_reg_write_q;
  logic             out_mem_read_q;
  logic             out_mem_write_q;
  logic [WIDTH-1:0] out_store_data_q;

  alu_zero_detect #(.WIDTH(WIDTH)) u_zero (
    .data_i (bus.alu_result),
    .zero_o (zero)
  );

  assign accept = bus.in_valid & in_ready;
  assign trap   = accept & bus.trap_oflo & bus.alu_oflo & op_can_trap(bus.operation);
  assign load   = accept & ~trap;
  assign drain  = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (trap) state_d = EXC;
      EXC:     if (bus.exc_ack) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // A pending exception is exactly the EXC state, so exc_req needs no separate flop.
  always_comb begin
    in_ready = 1'b0;
    exc_req  = 1'b0;
    case (state_q)
      RUN:     in_ready = (~out_valid_q | bus.out_ready) & ~bus.flush;
      EXC:     exc_req  = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // A trapping accept always coincides with a drain (or an empty register), so it
  // falls through to the drain term and never sets out_valid.
  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)  out_valid_d = 1'b0;
    else if (load)  out_valid_d = 1'b1;
    else if (drain) out_valid_d = 1'b0;
  end

  assign exc_epc_d = trap ? bus.pc : exc_epc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      exc_epc_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      exc_epc_q   <= exc_epc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result_q     <= '0;
      out_zero_q       <= 1'b0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      out_mem_read_q   <= 1'b0;
      out_mem_write_q  <= 1'b0;
      out_store_data_q <= '0;
    end else if (load) begin
      out_result_q     <= bus.alu_result;
      out_zero_q       <= zero;
      out_rd_q         <= bus.rd;
      out_reg_write_q  <= bus.reg_write;
      out_mem_read_q   <= bus.mem_read;
      out_mem_write_q  <= bus.mem_write;
      out_store_data_q <= bus.store_data;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.exc_req        = exc_req;
  assign bus.exc_epc        = exc_epc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_zero       = out_zero_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_reg_write  = out_reg_write_q;
  assign bus.out_mem_read   = out_mem_read_q;
  assign bus.out_mem_write  = out_mem_write_q;
  assign bus.out_store_data = out_store_data_q;

endmodule

// File: tb/tb_alu_ex_mem_reg.sv
// Directed bench for alu_ex_mem_reg with a scoreboard of registered instructions.
module tb_alu_ex_mem_reg;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   run_len;
  exp_t sb[$];
  exp_t held;

  alu_ex_mem_reg_if #(.WIDTH(32)) bus ();

  alu_ex_mem_reg #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1 ({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk1 ({tag, "_exc_req"}, bus.exc_req, 1'b0);
    chk32({tag, "_exc_epc"}, bus.exc_epc, 32'h0);
    chk32({tag, "_out_result"}, bus.out_result, 32'h0);
    chk1 ({tag, "_out_zero"}, bus.out_zero, 1'b0);
    chk32({tag, "_out_rd"}, {27'h0, bus.out_rd}, 32'h0);
    chk1 ({tag, "_out_rw"}, bus.out_reg_write, 1'b0);
    chk1 ({tag, "_out_mr"}, bus.out_mem_read, 1'b0);
    chk1 ({tag, "_out_mw"}, bus.out_mem_write, 1'b0);
    chk32({tag, "_out_sd"}, bus.out_store_data, 32'h0);
  endtask

  // Presents one instruction for exactly one cycle; expects it to be accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] res, input logic ofl,
                      input logic tr, input logic [31:0] pcv, input bit exp_load);
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.operation  = op;
    bus.alu_result = res;
    bus.alu_oflo   = ofl;
    bus.trap_oflo  = tr;
    bus.pc         = pcv;
    bus.rd         = 5'($urandom_range(1, 31));
    bus.reg_write  = 1'($urandom);
    bus.mem_read   = 1'($urandom);
    bus.mem_write  = 1'($urandom);
    bus.store_data = $urandom;
    if (exp_load) begin
      e.res  = res;
      e.zero = (res == 32'h0);
      e.rd   = bus.rd;
      e.rw   = bus.reg_write;
      e.mr   = bus.mem_read;
      e.mw   = bus.mem_write;
      e.sd   = bus.store_data;
      sb.push_back(e);
    end
    @(negedge clk);
    chk1("send_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard side: every MEM transfer must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) run_len <= run_len + 1;
    else               run_len <= 0;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=transfer expected=none");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk32("mon_result", bus.out_result, e.res);
        chk1 ("mon_zero", bus.out_zero, e.zero);
        chk32("mon_rd", {27'h0, bus.out_rd}, {27'h0, e.rd});
        chk1 ("mon_rw", bus.out_reg_write, e.rw);
        chk1 ("mon_mr", bus.out_mem_read, e.mr);
        chk1 ("mon_mw", bus.out_mem_write, e.mw);
        chk32("mon_sd", bus.out_store_data, e.sd);
      end
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    run_len = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_result = '0;
    bus.alu_oflo = 1'b0;
    bus.operation = OP_AND;
    bus.trap_oflo = 1'b0;
    bus.pc = '0;
    bus.rd = '0;
    bus.reg_write = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.store_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.exc_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("idle_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // 5+7 and 3-3
    send(OP_ADD, 32'd12, 1'b0, 1'b1, 32'h10, 1'b1);
    @(negedge clk);
    chk1("add_out_valid", bus.out_valid, 1'b1);
    chk1("add_exc_req", bus.exc_req, 1'b0);
    @(posedge clk); #1;
    send(OP_SUB, 32'd0, 1'b0, 1'b1, 32'h14, 1'b1);
    @(negedge clk);
    chk1("sub_out_zero", bus.out_zero, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("drained_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Four back-to-back accepts
    send(OP_ADD, 32'h0000_0001, 1'b0, 1'b1, 32'h20, 1'b1);
    send(OP_OR,  32'h0000_00f0, 1'b0, 1'b0, 32'h24, 1'b1);
    send(OP_AND, 32'h0000_0000, 1'b0, 1'b0, 32'h28, 1'b1);
    send(OP_SUB, 32'hffff_fffe, 1'b0, 1'b1, 32'h2c, 1'b1);
    @(negedge clk); #1;
    chk32("burst_run_len", run_len, 32'd4);
    @(posedge clk); #1;

    // Overflowing add traps
    send(OP_ADD, 32'h8000_0000, 1'b1, 1'b1, 32'h40, 1'b0);
    @(negedge clk);
    chk1 ("trap_out_valid", bus.out_valid, 1'b0);
    chk1 ("trap_exc_req", bus.exc_req, 1'b1);
    chk32("trap_exc_epc", bus.exc_epc, 32'h40);
    chk1 ("trap_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.pc = 32'h44;
    repeat (2) begin
      @(negedge clk);
      chk1 ("exc_in_ready", bus.in_ready, 1'b0);
      chk1 ("exc_hold_req", bus.exc_req, 1'b1);
      chk32("exc_hold_epc", bus.exc_epc, 32'h40);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.exc_ack = 1'b1;
    @(negedge clk);
    chk1("ack_req_still", bus.exc_req, 1'b1);
    @(posedge clk); #1;
    bus.exc_ack = 1'b0;
    @(negedge clk);
    chk1("ack_exc_req", bus.exc_req, 1'b0);
    chk1("ack_in_ready", bus.in_ready, 1'b1);
    chk1("ack_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Same operands without trap enable, SLT, and a logical op: no exception
    send(OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 32'h44, 1'b1);
    send(OP_SLT, 32'h8000_0000, 1'b1, 1'b1, 32'h48, 1'b1);
    send(OP_OR,  32'h8000_0000, 1'b1, 1'b1, 32'h4c, 1'b1);
    @(negedge clk);
    chk1 ("notrap_exc_req", bus.exc_req, 1'b0);
    chk32("notrap_result", bus.out_result, 32'h8000_0000);
    @(posedge clk); #1;

    // Stall for three cycles, then flush the held instruction
    bus.out_ready = 1'b0;
    send(OP_AND, 32'h0000_ff00, 1'b0, 1'b0, 32'h50, 1'b1);
    held = sb[0];
    bus.in_valid = 1'b1;
    bus.alu_result = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk1 ("stall_out_valid", bus.out_valid, 1'b1);
      chk1 ("stall_in_ready", bus.in_ready, 1'b0);
      chk32("stall_result", bus.out_result, held.res);
      chk32("stall_rd", {27'h0, bus.out_rd}, {27'h0, held.rd});
      chk32("stall_sd", bus.out_store_data, held.sd);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    void'(sb.pop_front());
    @(negedge clk);
    chk1("flush_out_valid", bus.out_valid, 1'b0);
    chk1("flush_exc_req", bus.exc_req, 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Flush blocks an incoming instruction in RUN
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk1("flush_blocks_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_no_accept", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Flush does not clear a pending exception; flush together with ack returns to RUN
    send(OP_SUB, 32'h7fff_ffff, 1'b1, 1'b1, 32'h60, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk1 ("exc_flush_req", bus.exc_req, 1'b1);
    chk32("exc_flush_epc", bus.exc_epc, 32'h60);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    bus.exc_ack = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.exc_ack = 1'b0;
    @(negedge clk);
    chk1("flush_ack_req", bus.exc_req, 1'b0);
    chk1("flush_ack_in_ready", bus.in_ready, 1'b1);
    chk1("flush_ack_out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of EXC wins over ack and incoming valid
    send(OP_ADD, 32'h8000_0000, 1'b1, 1'b1, 32'h80, 1'b0);
    @(negedge clk);
    chk1("pre_rst_exc_req", bus.exc_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.exc_ack = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.exc_ack = 1'b0;
    @(negedge clk);
    chk_all_zero("exc_reset");
    chk1("exc_reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    chk32("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
